lut_interp_pipe: RTL

- Downstream consumer of the sample-table lookup stage (sin / tanh tables).
- Takes the base sample, next sample and fractional index that stage produces, and emits the linearly interpolated Q1.15 value.
- Three-stage valid/ready pipeline with per-stage backpressure.
- Carries a sideband tag (voice/channel id) alongside each sample so effect engines can share one interpolator.

---
 rtl/lut_interp_pipe_pkg.sv | 32 +++
 rtl/lut_interp_pipe_if.sv | 38 +++
 rtl/lut_pipe_reg.sv | 64 ++++++
 rtl/lut_interp_pipe.sv | 139 +++++++++++++
 4 files changed

// File: rtl/lut_interp_pipe_pkg.sv
// -----------------------------------------------------------------------------
// lut_interp_pipe_pkg
// Shared constants, types and helpers for the LUT interpolation pipeline.
//   LUT_SAMPLE_W : sample width (signed Q1.15)
//   LUT_FRAC_W   : fractional index width, defaults to `LUT_FRAC_WIDTH (4)
//   LUT_TAG_W    : opaque sideband tag width
//   sample_t     : signed sample type
//   round_const  : half-LSB constant used by the optional rounding mode
//                  (LUT_INTERP_ROUND_EN)
// -----------------------------------------------------------------------------
`ifndef LUT_FRAC_WIDTH
`define LUT_FRAC_WIDTH 4
`endif

package lut_interp_pipe_pkg;

    localparam int LUT_SAMPLE_W = 16;
    localparam int LUT_FRAC_W   = `LUT_FRAC_WIDTH;
    localparam int LUT_TAG_W    = 4;

    typedef logic signed [LUT_SAMPLE_W-1:0] sample_t;

    // Value of one half LSB after a right shift by frac_w (0 when nothing is shifted).
    function automatic int unsigned round_const(input int unsigned frac_w);
        if (frac_w == 32'd0) begin
            return 32'd0;
        end else begin
            return 32'd1 << (frac_w - 32'd1);
        end
    endfunction

endpackage

// File: rtl/lut_interp_pipe_if.sv
// -----------------------------------------------------------------------------
// lut_interp_pipe_if
// Valid/ready bus bundle for lut_interp_pipe.
//   Input side : in_valid, in_ready, base_sample, next_sample, frac, in_tag
//   Output side: out_valid, out_ready, out_sample, out_tag
// Modports:
//   master : the environment (drives input beats, consumes output beats)
//   slave  : the interpolator
// -----------------------------------------------------------------------------
interface lut_interp_pipe_if #(
    parameter int SAMPLE_W = lut_interp_pipe_pkg::LUT_SAMPLE_W,
    parameter int FRAC_W   = lut_interp_pipe_pkg::LUT_FRAC_W,
    parameter int TAG_W    = lut_interp_pipe_pkg::LUT_TAG_W
);

    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] base_sample;
    logic [SAMPLE_W-1:0] next_sample;
    logic [FRAC_W-1:0]   frac;
    logic [TAG_W-1:0]    in_tag;

    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_sample;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output in_valid, base_sample, next_sample, frac, in_tag, out_ready,
        input  in_ready, out_valid, out_sample, out_tag
    );

    modport slave (
        input  in_valid, base_sample, next_sample, frac, in_tag, out_ready,
        output in_ready, out_valid, out_sample, out_tag
    );

endinterface

// File: rtl/lut_pipe_reg.sv
// -----------------------------------------------------------------------------
// lut_pipe_reg
// Generic valid/ready register slice. Holds one beat; accepts a new one when
// empty or when its current beat leaves in the same cycle, so a chain of these
// runs at one beat per cycle with no bubble.
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake (in_ready = this slice advances)
//   in_data              : upstream payload (W bits)
//   out_valid/out_ready  : downstream handshake
//   out_data             : registered payload
// -----------------------------------------------------------------------------
module lut_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_d;
    logic         valid_q;
    logic [W-1:0] data_d;
    logic [W-1:0] data_q;
    logic         advance_s;

    // Next-state: load when advancing; otherwise hold the stalled beat.
    always_comb begin
        advance_s = !valid_q || out_ready;
        valid_d   = valid_q;
        data_d    = data_q;
        if (advance_s) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Slice state register; reset empties the slice and clears its payload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/lut_interp_pipe.sv
// -----------------------------------------------------------------------------
// lut_interp_pipe
// Linear interpolator between two adjacent table samples, three-stage
// valid/ready pipeline with a sideband tag carried alongside each beat.
//   S1: diff = next - base at SAMPLE_W+1 bits (no wrap at 0x7FFF/0x8000)
//   S2: prod = diff * frac (frac zero-extended, signed multiply)
//   S3: result = base + (prod >>> FRAC_W), truncated to SAMPLE_W, drives out_*
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset; release is expected to be
//              synchronous to clk (done by the reset controller upstream)
//   bus      : lut_interp_pipe_if.slave (input beat, output beat, tags)
// Configuration:
//   LUT_INTERP_ROUND_EN defined   -> S3 rounds half-up before the shift
//   LUT_INTERP_ROUND_EN undefined -> S3 floors (plain arithmetic shift)
// -----------------------------------------------------------------------------
module lut_interp_pipe
    import lut_interp_pipe_pkg::*;
#(
    parameter int SAMPLE_W = LUT_SAMPLE_W,
    parameter int FRAC_W   = LUT_FRAC_W,
    parameter int TAG_W    = LUT_TAG_W
) (
    input logic               clk,
    input logic               reset_n,
    lut_interp_pipe_if.slave  bus
);

    localparam int DIFF_W = SAMPLE_W + 1;
    localparam int PROD_W = SAMPLE_W + FRAC_W + 2;
    localparam int S1_W   = SAMPLE_W + TAG_W + FRAC_W + DIFF_W;
    localparam int S2_W   = SAMPLE_W + TAG_W + PROD_W;
    localparam int S3_W   = SAMPLE_W + TAG_W;

`ifdef LUT_INTERP_ROUND_EN
    localparam logic signed [PROD_W:0] RND_C = (PROD_W+1)'(round_const(FRAC_W));
`endif

    // Stage 1 input side
    logic signed [DIFF_W-1:0]   s1_diff_s;
    logic        [S1_W-1:0]     s1_in_s;
    logic        [S1_W-1:0]     s1_out_s;
    logic                       s1_valid_s;

    // Stage 1 registered fields
    logic        [SAMPLE_W-1:0] s1_base_s;
    logic        [TAG_W-1:0]    s1_tag_s;
    logic        [FRAC_W-1:0]   s1_frac_s;
    logic signed [DIFF_W-1:0]   s1_diff_q_s;

    // Stage 2
    logic signed [PROD_W-1:0]   s2_prod_s;
    logic        [S2_W-1:0]     s2_in_s;
    logic        [S2_W-1:0]     s2_out_s;
    logic                       s2_valid_s;
    logic                       s2_ready_s;
    logic        [SAMPLE_W-1:0] s2_base_s;
    logic        [TAG_W-1:0]    s2_tag_s;
    logic signed [PROD_W-1:0]   s2_prod_q_s;

    // Stage 3
    logic signed [PROD_W:0]     s3_prod_adj_s;
    logic signed [PROD_W:0]     s3_shifted_s;
    logic        [PROD_W:0]     s3_base_ext_s;
    logic        [SAMPLE_W-1:0] s3_result_s;
    logic        [S3_W-1:0]     s3_in_s;
    logic        [S3_W-1:0]     s3_out_s;
    logic                       s3_ready_s;

    // S1 arithmetic: widen both operands by one sign bit so the full-scale
    // difference (e.g. 0x8000 - 0x7FFF = -65535) is representable.
    always_comb begin
        s1_diff_s = {bus.next_sample[SAMPLE_W-1], bus.next_sample}
                  - {bus.base_sample[SAMPLE_W-1], bus.base_sample};
        s1_in_s   = {bus.base_sample, bus.in_tag, bus.frac, s1_diff_s};
    end

    lut_pipe_reg #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (s1_in_s),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_out_s)
    );

    assign {s1_base_s, s1_tag_s, s1_frac_s, s1_diff_q_s} = s1_out_s;

    // S2 arithmetic: frac is unsigned, so it gets a zero MSB before the signed
    // multiply; both operands are sign-extended to the product width.
    always_comb begin
        s2_prod_s = PROD_W'(s1_diff_q_s) * PROD_W'($signed({1'b0, s1_frac_s}));
        s2_in_s   = {s1_base_s, s1_tag_s, s2_prod_s};
    end

    lut_pipe_reg #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (s2_in_s),
        .out_valid (s2_valid_s),
        .out_ready (s3_ready_s),
        .out_data  (s2_out_s)
    );

    assign {s2_base_s, s2_tag_s, s2_prod_q_s} = s2_out_s;

    // S3 arithmetic: one guard bit above the product keeps the rounding add
    // from overflowing; the final sum always lies between base and next, so
    // truncating to SAMPLE_W loses nothing.
    always_comb begin
`ifdef LUT_INTERP_ROUND_EN
        s3_prod_adj_s = {s2_prod_q_s[PROD_W-1], s2_prod_q_s} + RND_C;
`else
        s3_prod_adj_s = {s2_prod_q_s[PROD_W-1], s2_prod_q_s};
`endif
        s3_shifted_s  = s3_prod_adj_s >>> FRAC_W;
        s3_base_ext_s = {{(PROD_W + 1 - SAMPLE_W){s2_base_s[SAMPLE_W-1]}}, s2_base_s};
        s3_result_s   = SAMPLE_W'(s3_base_ext_s + s3_shifted_s);
        s3_in_s       = {s3_result_s, s2_tag_s};
    end

    lut_pipe_reg #(.W(S3_W)) u_s3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (s2_valid_s),
        .in_ready  (s3_ready_s),
        .in_data   (s3_in_s),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s3_out_s)
    );

    assign {bus.out_sample, bus.out_tag} = s3_out_s;

endmodule
